// File: rtl/imm_pkg.sv
// Shared types for the registered immediate generator: format select
// encoding and the output-buffer entry layout.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_U     = 3'b001,
        IMM_S     = 3'b010,
        IMM_J     = 3'b011,
        IMM_LD    = 3'b100,
        IMM_Z     = 3'b101,
        IMM_AUIPC = 3'b110,
        IMM_B     = 3'b111
    } imm_sel_e;

    // Entry fields are sized for the widest supported datapath and tag;
    // narrower configurations store zero-extended values and read back
    // only their low bits.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [IMM_MAX_W-1:0] pc;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction for every RV format, including CSR
// zimm and the fused AUIPC target (PC + upper immediate, carry dropped).
module imm_format
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           Instr,
    input  imm_sel_e              ImmSel,
    input  logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [DATA_WIDTH-1:0] u_imm;
    logic                  unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^Instr[6:0];

    assign u_imm = DATA_WIDTH'($signed({Instr[31:12], 12'b0}));

    always_comb begin
        imm = '0;
        case (ImmSel)
            IMM_I, IMM_LD: imm = DATA_WIDTH'($signed(Instr[31:20]));
            IMM_S:         imm = DATA_WIDTH'($signed({Instr[31:25], Instr[11:7]}));
            IMM_B:         imm = DATA_WIDTH'($signed({Instr[31], Instr[7], Instr[30:25],
                                                      Instr[11:8], 1'b0}));
            IMM_J:         imm = DATA_WIDTH'($signed({Instr[31], Instr[19:12], Instr[20],
                                                      Instr[30:21], 1'b0}));
            IMM_U:         imm = u_imm;
            IMM_AUIPC:     imm = PC + u_imm;
            IMM_Z:         imm = DATA_WIDTH'(Instr[19:15]);
            default:       imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: computes the immediate on acceptance and
// queues {imm, pc, tag} in a DEPTH-entry FIFO toward the execute stage.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_WIDTH-1:0]   Instr,
    input  logic [2:0]               ImmSel,
    input  logic [DATA_WIDTH-1:0]    PC,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ImmExt,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    imm_entry_t            mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] imm_val;
    imm_entry_t            wr_entry;
    logic                  push;
    logic                  pop;

    imm_format #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_format (
        .Instr  (Instr),
        .ImmSel (imm_sel_e'(ImmSel)),
        .PC     (PC),
        .imm    (imm_val)
    );

    // Handshake: a beat moves on a rising edge where valid && ready. in_ready
    // depends only on registered count, so a pop cannot open room for a push
    // in the same cycle; out_valid/head data hold until the beat is taken.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry     = '0;
        wr_entry.imm = IMM_MAX_W'(imm_val);
        wr_entry.pc  = IMM_MAX_W'(PC);
        wr_entry.tag = TAG_MAX_W'(in_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign ImmExt  = mem[rd_ptr].imm[DATA_WIDTH-1:0];
    assign out_pc  = mem[rd_ptr].pc[DATA_WIDTH-1:0];
    assign out_tag = mem[rd_ptr].tag[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances share one stimulus
// stream and are checked against an arithmetic model queue every cycle.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, pc;
    logic [2:0]  sel;
    logic [4:0]  tag;
    logic [63:0] pc64;

    assign pc64 = {32'h0000_0001, pc};

    logic        in_ready, out_valid, in_ready64, out_valid64;
    logic [31:0] imm_ext, out_pc;
    logic [63:0] imm_ext64, out_pc64;
    logic [4:0]  out_tag, out_tag64;
    logic [1:0]  count, count64;

    imm_gen_pipe #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Instr(instr), .ImmSel(sel), .PC(pc), .in_tag(tag), .out_valid(out_valid),
        .out_ready(out_ready), .ImmExt(imm_ext), .out_pc(out_pc), .out_tag(out_tag),
        .count(count)
    );

    imm_gen_pipe #(.DATA_WIDTH(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .Instr(instr), .ImmSel(sel), .PC(pc64), .in_tag(tag), .out_valid(out_valid64),
        .out_ready(out_ready), .ImmExt(imm_ext64), .out_pc(out_pc64), .out_tag(out_tag64),
        .count(count64)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sext(input longint val, input int bits);
        if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
        return val;
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] s,
                                              input logic [63:0] pcv, input int w);
        longint v;
        case (s)
            3'b000, 3'b100: v = sext(longint'(i[31:20]), 12);
            3'b010: v = sext(longint'({i[31:25], i[11:7]}), 12);
            3'b111: v = sext(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            3'b011: v = sext(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            3'b001: v = sext(longint'(i[31:12]) * 4096, 32);
            3'b110: v = longint'(pcv) + sext(longint'(i[31:12]) * 4096, 32);
            default: v = longint'(i[19:15]);
        endcase
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    typedef struct packed {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] pc;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   m_pushes = 0;

    always @(posedge clk) begin : model
        bit m_push, m_pop;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            m_push = in_valid && (exp_q.size() < DEPTH);
            m_pop  = out_ready && (exp_q.size() > 0);
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                exp_q.push_back('{imm32: model_imm(instr, sel, {32'h0, pc}, 32)[31:0],
                                  imm64: model_imm(instr, sel, pc64, 64),
                                  pc: pc, tag: tag});
                m_pushes++;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("count64", 64'(count64), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
        check("in_ready64", 64'(in_ready64), 64'(exp_q.size() != DEPTH));
        if (exp_q.size() != 0) begin
            check("imm32", 64'(imm_ext), 64'(exp_q[0].imm32));
            check("imm64", imm_ext64, exp_q[0].imm64);
            check("pc32", 64'(out_pc), 64'(exp_q[0].pc));
            check("pc64", out_pc64, {32'h0000_0001, exp_q[0].pc});
            check("tag", 64'(out_tag), 64'(exp_q[0].tag));
            check("tag64", 64'(out_tag64), 64'(exp_q[0].tag));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic [31:0] i, input logic [2:0] s,
                           input logic [31:0] p, input logic [4:0] t);
        instr = i; sel = s; pc = p; tag = t;
    endtask

    task automatic send(input logic [31:0] i, input logic [2:0] s,
                        input logic [31:0] p, input logic [4:0] t);
        set_req(i, s, p, t);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_valid"}, 64'(out_valid), 64'd0);
        check({where, "_ready"}, 64'(in_ready), 64'd1);
        check({where, "_imm"}, 64'(imm_ext), 64'd0);
        check({where, "_pc"}, 64'(out_pc), 64'd0);
        check({where, "_tag"}, 64'(out_tag), 64'd0);
        check({where, "_count"}, 64'(count), 64'd0);
        check({where, "_imm64"}, imm_ext64, 64'd0);
        check({where, "_pc64"}, out_pc64, 64'd0);
    endtask

    logic [31:0] vec_instr [8] = '{32'h00A00513, 32'hFE112E23, 32'h8000006F, 32'hFFC42083,
                                   32'hABCDE037, 32'hFFFFF017, 32'h00305073, 32'h00B50463};
    logic [2:0]  vec_sel   [8] = '{3'b000, 3'b010, 3'b011, 3'b100,
                                   3'b001, 3'b110, 3'b101, 3'b111};
    logic [7:0]  ready_pat = 8'b1011_0010;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(32'h0, 3'b000, 32'h0, 5'd0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        send(32'hFFF00093, IMM_I, 32'h0000_0100, 5'd1);
        check("lit_i_type", 64'(imm_ext), 64'hFFFF_FFFF);
        check("lit_i_valid", 64'(out_valid), 64'd1);
        send(32'hFE000EE3, IMM_B, 32'h0000_0104, 5'd2);
        check("lit_b_type", 64'(imm_ext), 64'hFFFF_FFFC);
        send(32'h12345017, IMM_AUIPC, 32'h0000_1000, 5'd3);
        check("lit_auipc", 64'(imm_ext), 64'h1234_6000);
        check("lit_auipc64", imm_ext64, 64'h0000_0001_1234_6000);
        check("lit_auipc_pc", 64'(out_pc), 64'h1000);
        send(32'h000FD073, IMM_Z, 32'h0000_1004, 5'd4);
        check("lit_zimm", 64'(imm_ext), 64'h1F);
        send(32'h800002B7, IMM_U, 32'h0000_1008, 5'd5);
        check("lit_u64", imm_ext64, 64'hFFFF_FFFF_8000_0000);
        check("lit_u32", 64'(imm_ext), 64'h8000_0000);
        @(negedge clk);

        // backpressure: third request must wait until a slot is freed
        out_ready = 1'b0;
        set_req(32'hFE112E23, IMM_S, 32'h2000, 5'd6); in_valid = 1'b1;
        @(negedge clk);
        set_req(32'h8000006F, IMM_J, 32'h2004, 5'd7);
        @(negedge clk);
        set_req(32'hFFC42083, IMM_LD, 32'h2008, 5'd8);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_count", 64'(count), 64'd2);
        check("bp_head", 64'(out_tag), 64'd6);
        @(negedge clk);
        check("bp_hold", 64'(count), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop1_tag", 64'(out_tag), 64'd7);
        check("bp_pop1_count", 64'(count), 64'd1);
        @(negedge clk);
        check("bp_third_tag", 64'(out_tag), 64'd8);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 64'(count), 64'd0);

        // flush with full buffer, then with room for the competing push
        out_ready = 1'b0;
        send(32'h00100093, IMM_I, 32'h3000, 5'd9);
        send(32'h00200093, IMM_I, 32'h3004, 5'd10);
        check("fl_full", 64'(count), 64'd2);
        set_req(32'h00300093, IMM_I, 32'h3008, 5'd11); in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        send(32'h00400093, IMM_I, 32'h300C, 5'd12);
        set_req(32'h00500093, IMM_I, 32'h3010, 5'd13); in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("fl_push_dropped", 64'(count), 64'd0);
        @(negedge clk);
        check("fl_still_empty", 64'(out_valid), 64'd0);

        // reset mid-stream with a competing push
        send(32'h00600093, IMM_I, 32'h4000, 5'd14);
        send(32'h00700093, IMM_I, 32'h4004, 5'd15);
        set_req(32'h00800093, IMM_I, 32'h4008, 5'd16); in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        check_reset_outputs("midrst");

        // directed vector stream under a fixed ready pattern
        for (int k = 0; k < 8; k++) begin
            int start;
            int waited;
            start = m_pushes;
            waited = 0;
            set_req(vec_instr[k], vec_sel[k], 32'h8000_0000 + 32'(k * 4), 5'(20 + k));
            in_valid = 1'b1;
            while (m_pushes == start && waited < 20) begin
                out_ready = ready_pat[(k + waited) % 8];
                @(negedge clk);
                waited++;
            end
            if (m_pushes == start) check("stream_accept_timeout", 64'(waited), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        check("final_drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
